color_fade_sequencer: RTL and testbench
=======================================

# color_fade_sequencer

Parametrised successor to the fixed-rate RGB colour stepper. Cycles the same 7-colour palette: red, orange, yellow, green, blue, indigo, purple. It adds configurable channel width, tick rate and hold time, optional linear cross-fade between neighbouring colours, reversible direction, an enable/freeze input and a wrap indicator. It drives the PWM generator duty inputs directly.

## Interface
- CW, 8: channel width in bits; legal range 8..16.
- TICK_DIV, 62500000: clk cycles per sequencer tick; must be ≥2.
- HOLD_TICKS, 1: ticks each palette colour is held; must be ≥1.
- FADE_SHIFT, 4: a fade takes 2^FADE_SHIFT ticks; legal range 1..8.
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  1 = run; 0 = freeze all counters, state and outputs.
- fade_en  in  1  1 = cross-fade between colours; 0 = hard step.
- dir  in  1  0 = forward (red→purple); 1 = reverse.
- r_out  out  CW  red duty value, registered.
- g_out  out  CW  green duty value, registered.
- b_out  out  CW  blue duty value, registered.
- color_idx  out  3  current base palette index, 0..6.
- wrap  out  1  one-cycle pulse when color_idx wraps.

## Operation
- **Palette (8-bit)**, indexed 0..6:
  - 0 red (255,0,0)
  - 1 orange (255,60,0)
  - 2 yellow (255,255,0)
  - 3 green (0,255,0)
  - 4 blue (0,0,255)
  - 5 indigo (8,46,84)
  - 6 purple (160,32,240)
  - Scaled to CW as P << (CW-8), zero-filled.
- **Prescaler**: tick_cnt runs 0..TICK_DIV-1 while en=1. The tick condition is en && tick_cnt==TICK_DIV-1. en=0 holds tick_cnt (no clear).
- **FSM** (updates only on tick):
  - IDLE → HOLD with idx=0.
  - HOLD: hold_cnt counts ticks. At the tick where hold_cnt==HOLD_TICKS-1, nxt is computed from dir:
    - forward: idx+1, with 6→0;
    - reverse: idx-1, with 0→6.
  - Then, if fade_en=1: go to FADE with k=1 and tgt latched = nxt.
  - Otherwise: stay in HOLD with idx=nxt and hold_cnt=0.
  - FADE: k increments per tick. At the tick with k==2^FADE_SHIFT-1: go to HOLD with idx=tgt, hold_cnt=0.
- **Outputs**:
  - IDLE: 0.
  - HOLD: palette[idx].
  - FADE: per channel, out = A + ((B−A)·k >>> FADE_SHIFT), where A=palette[idx] and B=palette[tgt].
  - Width: difference is signed CW+1 bits; product is signed CW+1+FADE_SHIFT bits; the shift is arithmetic (floor).
  - The result always lies in [min(A,B), max(A,B)] and is truncated to CW bits.
- **Indicators**:
  - color_idx = idx; it stays at the source colour during FADE.
  - wrap = 1 for exactly the clk cycle after the edge where idx changes 6→0 (forward) or 0→6 (reverse); 0 otherwise.
- **Sampling**:
  - dir and fade_en are sampled only at the end-of-HOLD tick.
  - Changing either during FADE does not alter the fade in progress.
- **Reset** (async assert, any state including mid-fade):
  - r_out, g_out, b_out = 0; color_idx = 0; wrap = 0.
  - State = IDLE; tick_cnt, hold_cnt and k = 0.

## Timing
- All outputs are registered. New values appear at the rising edge on which the tick condition is true; there is no further pipeline delay.
- First colour: with en=1 from release, red appears at the TICK_DIV-th rising edge after rst_n deasserts.
- Hard-step period per colour = HOLD_TICKS·TICK_DIV cycles.
- Fade-mode period per colour = (HOLD_TICKS + 2^FADE_SHIFT − 1)·TICK_DIV cycles. This gives 2^FADE_SHIFT−1 intermediate values, each lasting TICK_DIV cycles.
- en deasserted in the same cycle a tick would occur: no tick; everything freezes. Resuming with en=1 continues from the held tick_cnt.
- wrap is cleared on the cycle after its assertion even if en=0.

## Test plan
Bench parameters: CW=8, TICK_DIV=4, HOLD_TICKS=2, FADE_SHIFT=2 unless noted.

1. **Reset/start**: assert rst_n=0 mid-run → outputs 0, idx 0, wrap 0 immediately. Release with en=1, fade_en=0 → (255,0,0) at the 4th edge, then (255,60,0) 8 cycles later.
2. **Hard step forward**: run a full cycle → the seven palette triples in order, 8 cycles each. The purple→red edge gives a wrap pulse of exactly 1 cycle.
3. **Fade, positive slope**: red→orange with fade_en=1 → G = 0 (8 cycles), then 15, 30, 45 (4 cycles each), then 60. R stays 255; color_idx stays 0 until G reaches 60.
4. **Fade, negative slope**: yellow→green → R = 191, 127, 63, then 0. G stays 255 throughout.
5. **Reverse and freeze**: dir=1 from red → next colour purple (160,32,240) with a wrap pulse. en=0 for 20 cycles mid-fade → outputs and color_idx constant; the fade resumes with the remaining tick count unchanged.
6. **Width scaling**: CW=10, fade_en=0 → red = (1020,0,0); indigo = (32,184,336). A reset pulse during a fade returns all outputs to 0 asynchronously.

Source files
------------

// File: rtl/color_fade_sequencer.sv
// color_fade_sequencer: steps through a 7-colour RGB palette at a divided tick
// rate, optionally cross-fading linearly between neighbouring colours, in
// either direction, with a freeze input and a one-cycle wrap pulse.
module color_fade_sequencer #(
  parameter int CW         = 8,
  parameter int TICK_DIV   = 62500000,
  parameter int HOLD_TICKS = 1,
  parameter int FADE_SHIFT = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          fade_en,
  input  logic          dir,
  output logic [CW-1:0] r_out,
  output logic [CW-1:0] g_out,
  output logic [CW-1:0] b_out,
  output logic [2:0]    color_idx,
  output logic          wrap
);

  localparam int TW = $clog2(TICK_DIV);
  localparam int HW = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
  localparam int KW = FADE_SHIFT;
  localparam int PW = CW + KW + 2;

  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_TICKS - 1);
  localparam logic [KW-1:0] K_LAST    = {KW{1'b1}};

  typedef enum logic [1:0] {S_IDLE, S_HOLD, S_FADE} state_t;

  state_t          r_state, w_state;
  logic [TW-1:0]   r_tick_cnt;
  logic [HW-1:0]   r_hold_cnt, w_hold_cnt;
  logic [KW-1:0]   r_k, w_k;
  logic [2:0]      r_idx, w_idx, r_tgt, w_tgt, w_nxt;
  logic [CW-1:0]   r_r, r_g, r_b;
  logic            r_wrap;
  logic            w_tick, w_wrap_evt;
  logic [3*CW-1:0] w_a, w_b, w_rgb;

  // Palette entry scaled up to CW bits, packed as {r,g,b}.
  function automatic logic [3*CW-1:0] pal(input logic [2:0] i);
    logic [23:0] p;
    case (i)
      3'd0:    p = 24'hFF0000;
      3'd1:    p = 24'hFF3C00;
      3'd2:    p = 24'hFFFF00;
      3'd3:    p = 24'h00FF00;
      3'd4:    p = 24'h0000FF;
      3'd5:    p = 24'h082E54;
      3'd6:    p = 24'hA020F0;
      default: p = 24'h000000;
    endcase
    return {CW'(p[23:16]) << (CW - 8), CW'(p[15:8]) << (CW - 8),
            CW'(p[7:0]) << (CW - 8)};
  endfunction

  // a + floor((b-a)*k / 2^FADE_SHIFT); the result stays between a and b, so
  // dropping the upper bits of the sum is exact.
  function automatic logic [CW-1:0] lerp(input logic [CW-1:0] a,
                                         input logic [CW-1:0] b,
                                         input logic [KW-1:0] k);
    logic signed [CW:0]   d;
    logic signed [PW-1:0] p;
    d = $signed({1'b0, b}) - $signed({1'b0, a});
    p = PW'(d) * PW'($signed({1'b0, k}));
    p = p >>> FADE_SHIFT;
    return a + p[CW-1:0];
  endfunction

  assign w_tick = en && (r_tick_cnt == TICK_LAST);

  // Prescaler: free-running while enabled, held (not cleared) when frozen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_tick_cnt <= '0;
    else if (en)     r_tick_cnt <= (r_tick_cnt == TICK_LAST) ? '0 : r_tick_cnt + 1'b1;
  end

  // Sequencer state register, advanced only on a tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_idx      <= '0;
      r_tgt      <= '0;
      r_hold_cnt <= '0;
      r_k        <= '0;
    end else if (w_tick) begin
      r_state    <= w_state;
      r_idx      <= w_idx;
      r_tgt      <= w_tgt;
      r_hold_cnt <= w_hold_cnt;
      r_k        <= w_k;
    end
  end

  // Next state: dir/fade_en matter only on the last hold tick.
  always_comb begin
    w_state    = r_state;
    w_idx      = r_idx;
    w_tgt      = r_tgt;
    w_hold_cnt = r_hold_cnt;
    w_k        = r_k;
    if (dir) w_nxt = (r_idx == 3'd0) ? 3'd6 : r_idx - 3'd1;
    else     w_nxt = (r_idx == 3'd6) ? 3'd0 : r_idx + 3'd1;
    case (r_state)
      S_IDLE: begin
        w_state    = S_HOLD;
        w_idx      = 3'd0;
        w_hold_cnt = '0;
      end
      S_HOLD: begin
        if (r_hold_cnt == HOLD_LAST) begin
          if (fade_en) begin
            w_state = S_FADE;
            w_tgt   = w_nxt;
            w_k     = KW'(1);
          end else begin
            w_idx      = w_nxt;
            w_hold_cnt = '0;
          end
        end else begin
          w_hold_cnt = r_hold_cnt + 1'b1;
        end
      end
      S_FADE: begin
        if (r_k == K_LAST) begin
          w_state    = S_HOLD;
          w_idx      = r_tgt;
          w_hold_cnt = '0;
        end else begin
          w_k = r_k + 1'b1;
        end
      end
      default: w_state = S_IDLE;
    endcase
  end

  assign w_wrap_evt = ((r_idx == 3'd6) && (w_idx == 3'd0)) ||
                      ((r_idx == 3'd0) && (w_idx == 3'd6));

  // Colour for the state being entered, so outputs change on the tick edge.
  always_comb begin
    w_a = pal(w_idx);
    w_b = pal(w_tgt);
    case (w_state)
      S_HOLD:  w_rgb = w_a;
      S_FADE:  w_rgb = {lerp(w_a[3*CW-1 -: CW], w_b[3*CW-1 -: CW], w_k),
                        lerp(w_a[2*CW-1 -: CW], w_b[2*CW-1 -: CW], w_k),
                        lerp(w_a[CW-1:0],       w_b[CW-1:0],       w_k)};
      default: w_rgb = '0;
    endcase
  end

  // Registered duty outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_r <= '0;
      r_g <= '0;
      r_b <= '0;
    end else if (w_tick) begin
      {r_r, r_g, r_b} <= w_rgb;
    end
  end

  // Wrap pulse lasts one cycle regardless of en.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_wrap <= 1'b0;
    else        r_wrap <= w_tick && w_wrap_evt;
  end

  assign r_out     = r_r;
  assign g_out     = r_g;
  assign b_out     = r_b;
  assign color_idx = r_idx;
  assign wrap      = r_wrap;

endmodule

// File: tb/tb_color_fade_sequencer.sv
// Bench for color_fade_sequencer: directed scenarios plus random en/dir/fade
// traffic, compared every cycle against a phase-based colour model, for an
// 8-bit and a 10-bit instance driven by the same inputs.
module tb_color_fade_sequencer;
  localparam int TD  = 4;
  localparam int HT  = 2;
  localparam int FS  = 2;
  localparam int NST = 1 << FS;

  logic clk, rst_n, en, fade_en, dir;
  logic [7:0] r8, g8, b8;
  logic [9:0] r10, g10, b10;
  logic [2:0] idx8, idx10;
  logic wrap8, wrap10;
  logic [27:0] obs8, exp8, frozen;
  logic [33:0] obs10, exp10;
  int n_chk = 0, n_fail = 0;

  color_fade_sequencer #(.CW(8), .TICK_DIV(TD), .HOLD_TICKS(HT), .FADE_SHIFT(FS)) dut8 (
    .clk(clk), .rst_n(rst_n), .en(en), .fade_en(fade_en), .dir(dir),
    .r_out(r8), .g_out(g8), .b_out(b8), .color_idx(idx8), .wrap(wrap8));

  color_fade_sequencer #(.CW(10), .TICK_DIV(TD), .HOLD_TICKS(HT), .FADE_SHIFT(FS)) dut10 (
    .clk(clk), .rst_n(rst_n), .en(en), .fade_en(fade_en), .dir(dir),
    .r_out(r10), .g_out(g10), .b_out(b10), .color_idx(idx10), .wrap(wrap10));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign obs8  = {r8, g8, b8, idx8, wrap8};
  assign obs10 = {r10, g10, b10, idx10, wrap10};

  function automatic int pal8(int i, int c);
    int t[3];
    case (i)
      0: t = '{255, 0, 0};
      1: t = '{255, 60, 0};
      2: t = '{255, 255, 0};
      3: t = '{0, 255, 0};
      4: t = '{0, 0, 255};
      5: t = '{8, 46, 84};
      default: t = '{160, 32, 240};
    endcase
    return t[c];
  endfunction

  // Model: phase counts ticks since the current colour became the base one;
  // phases HT.. are fade steps with weight k = phase-HT+1.
  int m_cnt, m_phase, m_idx, m_tgt;
  bit m_started, m_fading, m_wrap;

  function automatic int chexp(int c, int s, bit started, bit fading, int idx, int tgt, int phase);
    int a, b, d, q;
    if (!started) return 0;
    a = pal8(idx, c) * (1 << s);
    if (!fading) return a;
    b = pal8(tgt, c) * (1 << s);
    d = (b - a) * (phase - HT + 1);
    q = (d >= 0) ? d / NST : -((-d + NST - 1) / NST);
    return a + q;
  endfunction

  always @(posedge clk or negedge rst_n) begin : model
    int nxt;
    if (!rst_n) begin
      m_cnt <= 0; m_phase <= 0; m_idx <= 0; m_tgt <= 0;
      m_started <= 0; m_fading <= 0; m_wrap <= 0;
    end else begin
      m_wrap <= 1'b0;
      if (en) begin
        m_cnt <= (m_cnt + 1) % TD;
        if (m_cnt == TD - 1) begin
          if (!m_started) begin
            m_started <= 1; m_idx <= 0; m_phase <= 0;
          end else if (m_fading) begin
            if (m_phase == HT + NST - 2) begin
              m_fading <= 0; m_idx <= m_tgt; m_phase <= 0;
              m_wrap <= (m_tgt - m_idx == 6) || (m_idx - m_tgt == 6);
            end else m_phase <= m_phase + 1;
          end else if (m_phase < HT - 1) begin
            m_phase <= m_phase + 1;
          end else begin
            nxt = dir ? (m_idx + 6) % 7 : (m_idx + 1) % 7;
            if (fade_en) begin
              m_fading <= 1; m_tgt <= nxt; m_phase <= m_phase + 1;
            end else begin
              m_idx <= nxt; m_phase <= 0;
              m_wrap <= (nxt - m_idx == 6) || (m_idx - nxt == 6);
            end
          end
        end
      end
    end
  end

  always_comb begin
    exp8 = {8'(chexp(0, 0, m_started, m_fading, m_idx, m_tgt, m_phase)),
            8'(chexp(1, 0, m_started, m_fading, m_idx, m_tgt, m_phase)),
            8'(chexp(2, 0, m_started, m_fading, m_idx, m_tgt, m_phase)),
            3'(m_idx), m_wrap};
    exp10 = {10'(chexp(0, 2, m_started, m_fading, m_idx, m_tgt, m_phase)),
             10'(chexp(1, 2, m_started, m_fading, m_idx, m_tgt, m_phase)),
             10'(chexp(2, 2, m_started, m_fading, m_idx, m_tgt, m_phase)),
             3'(m_idx), m_wrap};
  end

  // Reset then release on a negedge; the n-th following negedge is sample n.
  task automatic restart(input logic f, input logic d);
    @(negedge clk); rst_n = 1'b0; en = 1'b1; fade_en = f; dir = d;
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_reset;
    restart(1'b0, 1'b0);
    repeat (10) @(negedge clk);
    @(posedge clk); #2; rst_n = 1'b0; #1;
    n_chk++;
    if (obs8 !== 28'd0 || obs10 !== 34'd0) begin
      n_fail++; $display("FAIL reset_async: got %h/%h want 0", obs8, obs10);
    end
    @(negedge clk); rst_n = 1'b1;
    for (int s = 1; s <= 12; s++) begin
      @(negedge clk);
      n_chk++;
      if (obs8 !== exp8) begin n_fail++; $display("FAIL reset_model s=%0d: got %h want %h", s, obs8, exp8); end
      if (s == 3) begin
        n_chk++;
        if (obs8 !== 28'd0) begin n_fail++; $display("FAIL reset_pre_red: got %h want 0", obs8); end
      end
      if (s == 4 || s == 11) begin
        n_chk++;
        if ({r8, g8, b8} !== {8'd255, 8'd0, 8'd0}) begin
          n_fail++; $display("FAIL reset_red s=%0d: got %h want ff0000", s, {r8, g8, b8});
        end
      end
      if (s == 12) begin
        n_chk++;
        if ({r8, g8, b8} !== {8'd255, 8'd60, 8'd0}) begin
          n_fail++; $display("FAIL reset_orange: got %h want ff3c00", {r8, g8, b8});
        end
      end
    end
  endtask

  task automatic test_hard_step;
    int nwrap = 0;
    restart(1'b0, 1'b0);
    for (int s = 1; s <= 62; s++) begin
      @(negedge clk);
      nwrap += int'(wrap8);
      n_chk++;
      if (obs8 !== exp8) begin n_fail++; $display("FAIL hard_model s=%0d: got %h want %h", s, obs8, exp8); end
      if (s >= 4 && (s - 4) % 8 == 0) begin
        int j = ((s - 4) / 8) % 7;
        n_chk++;
        if ({r8, g8, b8, idx8} !== {8'(pal8(j, 0)), 8'(pal8(j, 1)), 8'(pal8(j, 2)), 3'(j)}) begin
          n_fail++; $display("FAIL hard_colour s=%0d: got %h want idx %0d", s, {r8, g8, b8, idx8}, j);
        end
      end
      if (s == 60) begin
        n_chk++;
        if (wrap8 !== 1'b1) begin n_fail++; $display("FAIL hard_wrap: got %b want 1", wrap8); end
      end
    end
    n_chk++;
    if (nwrap != 1) begin n_fail++; $display("FAIL hard_wrap_count: got %0d want 1", nwrap); end
  endtask

  task automatic test_fade_pos;
    restart(1'b1, 1'b0);
    for (int s = 1; s <= 24; s++) begin
      @(negedge clk);
      n_chk++;
      if (obs8 !== exp8) begin n_fail++; $display("FAIL fpos_model s=%0d: got %h want %h", s, obs8, exp8); end
      if (s == 11 || s == 12 || s == 16 || s == 20 || s == 23 || s == 24) begin
        logic [7:0] eg;
        logic [2:0] ei;
        eg = (s == 11) ? 8'd0 : (s == 12) ? 8'd15 : (s == 16) ? 8'd30 : (s == 24) ? 8'd60 : 8'd45;
        ei = (s == 24) ? 3'd1 : 3'd0;
        n_chk++;
        if ({r8, g8, b8, idx8} !== {8'd255, eg, 8'd0, ei}) begin
          n_fail++; $display("FAIL fpos_step s=%0d: got %h want %h", s, {r8, g8, b8, idx8}, {8'd255, eg, 8'd0, ei});
        end
      end
    end
  endtask

  // Continues the run left by test_fade_pos.
  task automatic test_fade_neg;
    for (int s = 25; s <= 64; s++) begin
      @(negedge clk);
      n_chk++;
      if (obs8 !== exp8) begin n_fail++; $display("FAIL fneg_model s=%0d: got %h want %h", s, obs8, exp8); end
      if (s == 52 || s == 56 || s == 60 || s == 63 || s == 64) begin
        logic [7:0] er;
        logic [2:0] ei;
        er = (s == 52) ? 8'd191 : (s == 56) ? 8'd127 : (s == 64) ? 8'd0 : 8'd63;
        ei = (s == 64) ? 3'd3 : 3'd2;
        n_chk++;
        if ({r8, g8, b8, idx8} !== {er, 8'd255, 8'd0, ei}) begin
          n_fail++; $display("FAIL fneg_step s=%0d: got %h want %h", s, {r8, g8, b8, idx8}, {er, 8'd255, 8'd0, ei});
        end
      end
    end
  endtask

  task automatic test_reverse_freeze;
    restart(1'b0, 1'b1);
    for (int s = 1; s <= 62; s++) begin
      @(negedge clk);
      n_chk++;
      if (obs8 !== exp8) begin n_fail++; $display("FAIL rev_model s=%0d: got %h want %h", s, obs8, exp8); end
      if (s == 12) begin
        n_chk++;
        if (obs8 !== {8'd160, 8'd32, 8'd240, 3'd6, 1'b1}) begin
          n_fail++; $display("FAIL rev_purple: got %h want a020f0 idx6 wrap1", obs8);
        end
      end
      if (s == 13) begin
        n_chk++;
        if (wrap8 !== 1'b0) begin n_fail++; $display("FAIL rev_wrap_len: got %b want 0", wrap8); end
        fade_en = 1'b1;
      end
      if (s == 21) begin frozen = obs8; en = 1'b0; end
      if (s >= 22 && s <= 43) begin
        n_chk++;
        if (obs8 !== frozen) begin n_fail++; $display("FAIL freeze_hold s=%0d: got %h want %h", s, obs8, frozen); end
      end
      if (s == 30) begin dir = 1'b0; fade_en = 1'b0; end
      if (s == 41) en = 1'b1;
      if (s == 44) begin
        n_chk++;
        if ({r8, g8, b8} !== {8'd84, 8'd39, 8'd162}) begin
          n_fail++; $display("FAIL freeze_resume: got %h want 5427a2", {r8, g8, b8});
        end
      end
      if (s == 51 || s == 52) begin
        n_chk++;
        if (idx8 !== ((s == 51) ? 3'd6 : 3'd5)) begin
          n_fail++; $display("FAIL freeze_idx s=%0d: got %0d", s, idx8);
        end
      end
      if (s == 60) begin
        n_chk++;
        if (idx8 !== 3'd6) begin n_fail++; $display("FAIL late_dir: got %0d want 6", idx8); end
      end
    end
  endtask

  task automatic test_width;
    restart(1'b0, 1'b0);
    for (int s = 1; s <= 54; s++) begin
      @(negedge clk);
      n_chk++;
      if (obs10 !== exp10) begin n_fail++; $display("FAIL w10_model s=%0d: got %h want %h", s, obs10, exp10); end
      if (s == 4) begin
        n_chk++;
        if ({r10, g10, b10} !== {10'd1020, 10'd0, 10'd0}) begin
          n_fail++; $display("FAIL w10_red: got %h want (1020,0,0)", {r10, g10, b10});
        end
      end
      if (s == 44) begin
        n_chk++;
        if ({r10, g10, b10, idx10} !== {10'd32, 10'd184, 10'd336, 3'd5}) begin
          n_fail++; $display("FAIL w10_indigo: got %h want (32,184,336) idx5", {r10, g10, b10, idx10});
        end
      end
      if (s == 45) fade_en = 1'b1;
    end
    @(posedge clk); #2; rst_n = 1'b0; #1;
    n_chk++;
    if (obs8 !== 28'd0 || obs10 !== 34'd0) begin
      n_fail++; $display("FAIL w10_fade_reset: got %h/%h want 0", obs8, obs10);
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_random;
    restart(1'b0, 1'b0);
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      n_chk++;
      if (obs8 !== exp8 || obs10 !== exp10) begin
        n_fail++; $display("FAIL rand_model c=%0d: got %h/%h want %h/%h", c, obs8, obs10, exp8, exp10);
      end
      rst_n = ($urandom_range(0, 399) != 0);
      en = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 15) == 0) fade_en = ~fade_en;
      if ($urandom_range(0, 15) == 0) dir = ~dir;
    end
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b1; en = 1'b0; fade_en = 1'b0; dir = 1'b0; frozen = '0;
    #2 rst_n = 1'b0;
    test_reset();
    test_hard_step();
    test_fade_pos();
    test_fade_neg();
    test_reverse_freeze();
    test_width();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
